// File: rtl/weighted_rr_pkg.sv
// rtl/weighted_rr_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package weighted_rr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Widest one-hot vector the index helper accepts; callers zero-extend into it.
   localparam int MAX_N = 256;

   function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating first-one search starting at a given index
module rr_pick
   import weighted_rr_pkg::*;
#(
   parameter int N   = 16,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_start,
   output logic           o_found,
   output logic [N-1:0]   o_winner,
   output logic [IDW-1:0] o_winner_idx
);

   logic [2*N-1:0] w_rot_dbl;
   logic [2*N-1:0] w_back_dbl;
   logic [N-1:0]   w_rot;
   logic [N-1:0]   w_iso;

   // Rotate so i_start lands at bit 0, isolate the lowest set bit, rotate back.
   assign w_rot_dbl  = {i_req, i_req} >> i_start;
   assign w_rot      = w_rot_dbl[N-1:0];
   assign w_iso      = w_rot & (~w_rot + N'(1));
   assign w_back_dbl = {w_iso, w_iso} << i_start;

   assign o_winner     = w_back_dbl[2*N-1:N];
   assign o_found      = |i_req;
   assign o_winner_idx = IDW'(onehot_to_idx(MAX_N'(o_winner)));

endmodule

// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - registered weighted round-robin arbiter with burst credit and lock
module weighted_rr_arbiter
   import weighted_rr_pkg::*;
#(
   parameter  int N   = 16,
   parameter  int WW  = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
   input  logic            lock,
   output logic [N-1:0]    grant,
   output logic [IDW-1:0]  grant_id,
   output logic            grant_valid
);

   state_t         r_state, w_next_state;
   logic [IDW-1:0] r_ptr, w_next_ptr, w_start;
   logic [WW-1:0]  r_credit, w_next_credit, w_wfield, w_eff_weight;
   logic [N-1:0]   r_grant, w_next_grant, w_winner;
   logic [IDW-1:0] r_grant_id, w_next_id, w_winner_idx;
   logic           r_valid, w_next_valid, w_found, w_owner_req, w_issue;

   // r_ptr doubles as the current owner while BUSY, so one search start serves every case.
   assign w_start     = (r_ptr == IDW'(N-1)) ? '0 : r_ptr + IDW'(1);
   assign w_owner_req = req[r_ptr];

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .i_req        (req),
      .i_start      (w_start),
      .o_found      (w_found),
      .o_winner     (w_winner),
      .o_winner_idx (w_winner_idx)
   );

   assign w_wfield     = weight[int'(w_winner_idx)*WW +: WW];
   assign w_eff_weight = (w_wfield == '0) ? WW'(1) : w_wfield;

   always_comb begin
      w_next_state  = r_state;
      w_next_ptr    = r_ptr;
      w_next_credit = r_credit;
      w_next_grant  = r_grant;
      w_next_id     = r_grant_id;
      w_next_valid  = r_valid;
      w_issue       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) w_issue = 1'b1;
         end
         BUSY: begin
            if (!w_owner_req) begin
               if (w_found) begin
                  w_issue = 1'b1;
               end else begin
                  w_next_state = IDLE;
                  w_next_grant = '0;
                  w_next_id    = '0;
                  w_next_valid = 1'b0;
               end
            end else if (!lock) begin
               if (r_credit > WW'(1)) w_next_credit = r_credit - WW'(1);
               else                   w_issue       = 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
      if (w_issue) begin
         w_next_state  = BUSY;
         w_next_grant  = w_winner;
         w_next_id     = w_winner_idx;
         w_next_valid  = 1'b1;
         w_next_credit = w_eff_weight;
         w_next_ptr    = w_winner_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= IDW'(N-1);
         r_credit   <= '0;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_ptr      <= w_next_ptr;
         r_credit   <= w_next_credit;
         r_grant    <= w_next_grant;
         r_grant_id <= w_next_id;
         r_valid    <= w_next_valid;
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grant_id;
   assign grant_valid = r_valid;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - directed self-checking bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] weight;
   logic        lock;
   logic [3:0]  grant;
   logic [1:0]  grant_id;
   logic        grant_valid;

   int tests;
   int fails;

   weighted_rr_arbiter #(.N(4), .WW(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .weight      (weight),
      .lock        (lock),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] exp);
      logic [1:0] exp_id;
      exp_id = 2'd0;
      for (int i = 0; i < 4; i++) if (exp[i]) exp_id = 2'(i);
      tests++;
      assert (grant === exp) else begin
         fails++;
         $error("FAIL %s grant: got %b expected %b", tag, grant, exp);
      end
      tests++;
      assert (grant_valid === (exp != 4'b0)) else begin
         fails++;
         $error("FAIL %s grant_valid: got %b expected %b", tag, grant_valid, (exp != 4'b0));
      end
      if (exp != 4'b0) begin
         tests++;
         assert (grant_id === exp_id) else begin
            fails++;
            $error("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, exp_id);
         end
      end
   endtask

   task automatic step(input string tag, input logic [3:0] exp);
      tick();
      chk(tag, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, 4'b0000);
      tests++;
      assert (grant_id === 2'd0) else begin
         fails++;
         $error("FAIL %s grant_id: got %0d expected 0", tag, grant_id);
      end
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      req    = 4'b0000;
      weight = 16'h1111;
      lock   = 1'b0;
      tick();
      tick();
      chk_reset("reset");

      // sole requester keeps the grant with no bubble
      rst_n = 1'b1;
      req   = 4'b0001;
      step("t1_c0", 4'b0001);
      step("t1_c1", 4'b0001);
      step("t1_c2", 4'b0001);
      step("t1_c3", 4'b0001);

      // all requesting, unit weights: one-cycle rotation from index 0
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      chk_reset("t2_rst");
      rst_n = 1'b1;
      req   = 4'b1111;
      step("t2_r0", 4'b0001);
      step("t2_r1", 4'b0010);
      step("t2_r2", 4'b0100);
      step("t2_r3", 4'b1000);
      step("t2_r4", 4'b0001);

      // weighted bursts 3/2, then weight 0 takes effect only at the next issue
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      rst_n  = 1'b1;
      weight = 16'h1213;
      req    = 4'b0101;
      step("t3_a0", 4'b0001);
      step("t3_a1", 4'b0001);
      step("t3_a2", 4'b0001);
      step("t3_b0", 4'b0100);
      step("t3_b1", 4'b0100);
      step("t3_a3", 4'b0001);
      step("t3_a4", 4'b0001);
      weight = 16'h1210;
      step("t3_a5", 4'b0001);
      step("t3_b2", 4'b0100);
      step("t3_b3", 4'b0100);
      step("t3_w0", 4'b0001);
      step("t3_b4", 4'b0100);

      // owner release hands over at once with reloaded credit, then idle
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      rst_n  = 1'b1;
      weight = 16'h4444;
      req    = 4'b0011;
      step("t4_o0", 4'b0001);
      step("t4_o1", 4'b0001);
      req = 4'b0010;
      step("t4_h0", 4'b0010);
      req = 4'b0011;
      step("t4_h1", 4'b0010);
      step("t4_h2", 4'b0010);
      step("t4_h3", 4'b0010);
      step("t4_next", 4'b0001);
      req = 4'b0000;
      step("t4_idle0", 4'b0000);
      step("t4_idle1", 4'b0000);

      // lock freezes credit; one more cycle after release, then hand over
      rst_n = 1'b0;
      tick();
      rst_n  = 1'b1;
      weight = 16'h1121;
      req    = 4'b0110;
      step("t5_g", 4'b0010);
      lock = 1'b1;
      step("t5_l0", 4'b0010);
      step("t5_l1", 4'b0010);
      step("t5_l2", 4'b0010);
      lock = 1'b0;
      step("t5_last", 4'b0010);
      step("t5_next", 4'b0100);

      // mid-burst reset drops the grant and restarts the search at index 0
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      rst_n  = 1'b1;
      weight = 16'h4444;
      req    = 4'b1111;
      step("t6_b0", 4'b0001);
      step("t6_b1", 4'b0001);
      rst_n = 1'b0;
      tick();
      chk_reset("t6_rst");
      rst_n = 1'b1;
      step("t6_first", 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
